alu_issue_ctrl: RTL and testbench

Upstream issue stage for the 32-bit combinational ALU (3-bit Op_code, operands A/B, result Y).
- Buffers operation requests in a small FIFO and drives the ALU from registered operands.
- Captures Y one cycle after issue and presents it downstream with a valid/ready handshake.
- Keeps an accumulator of the last result so commands can chain without software round-trips.

---
 rtl/alu_issue_ctrl.sv | 166 ++++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// Issue stage in front of a 32-bit combinational ALU. Commands are buffered in a
// small FIFO, issued one at a time from registered operands, and the ALU result is
// captured one cycle later and offered downstream with a valid/ready handshake.
// An accumulator keeps the last result so commands can chain on it.
module alu_issue_ctrl #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [31:0]      in_a,
    input  logic [31:0]      in_b,
    input  logic             in_use_acc,
    input  logic             acc_clr,
    output logic [2:0]       alu_op_code,
    output logic [31:0]      alu_a,
    output logic [31:0]      alu_b,
    input  logic [31:0]      alu_y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_y,
    output logic             out_zero,
    output logic [CNT_W-1:0] fifo_count
);

    localparam int unsigned     PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    typedef enum logic [1:0] {StIdle, StIssue, StHold} state_e;

    typedef struct packed {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        use_acc;
    } cmd_t;

    cmd_t             mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push, pop, fifo_empty;
    cmd_t             head;

    state_e           state_q, state_d;
    logic             capture;
    logic             out_valid_q, out_valid_d;
    logic [31:0]      out_y_q;
    logic             out_zero_q;
    logic [31:0]      acc_q;
    logic [2:0]       alu_op_q;
    logic [31:0]      alu_a_q, alu_b_q;

    // Ready depends only on the registered count: a pop in the same cycle does
    // not free a slot until the next cycle.
    assign in_ready   = (count_q < DEPTH_CNT);
    assign push       = in_valid && in_ready;
    assign fifo_empty = (count_q == '0);
    assign head       = mem_q[rd_ptr_q];

    // FIFO storage, written on push only.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= cmd_t'{op: in_op, a: in_a, b: in_b, use_acc: in_use_acc};
        end
    end

    // Occupancy: simultaneous push and pop leave the count unchanged.
    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // FIFO pointers and count; pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    // Issue FSM: decides when to pop, when to capture, and the result valid flag.
    always_comb begin
        state_d     = state_q;
        pop         = 1'b0;
        capture     = 1'b0;
        out_valid_d = out_valid_q;
        unique case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                capture     = 1'b1;
                out_valid_d = 1'b1;
                state_d     = StHold;
            end
            StHold: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        state_d = StIssue;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State register, issue operands, captured result and accumulator.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            alu_op_q    <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            out_valid_q <= 1'b0;
            out_y_q     <= '0;
            out_zero_q  <= 1'b0;
            acc_q       <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            if (pop) begin
                alu_op_q <= head.op;
                alu_a_q  <= head.use_acc ? acc_q : head.a;
                alu_b_q  <= head.b;
            end
            if (capture) begin
                out_y_q    <= alu_y;
                out_zero_q <= (alu_y == '0);
            end
            // Clear has priority over a coincident capture.
            if (acc_clr) begin
                acc_q <= '0;
            end else if (capture) begin
                acc_q <= alu_y;
            end
        end
    end

    assign alu_op_code = alu_op_q;
    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign out_valid   = out_valid_q;
    assign out_y       = out_y_q;
    assign out_zero    = out_zero_q;
    assign fifo_count  = count_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural ALU model on the alu_* port.
module tb_alu_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_op;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        in_use_acc;
    logic        acc_clr;
    logic [2:0]  alu_op_code;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [31:0] alu_y;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_y;
    logic        out_zero;
    logic [2:0]  fifo_count;

    int tests = 0;
    int fails = 0;

    alu_issue_ctrl #(
        .DEPTH(4),
        .CNT_W(3)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_use_acc (in_use_acc),
        .acc_clr    (acc_clr),
        .alu_op_code(alu_op_code),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_y      (alu_y),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_y      (out_y),
        .out_zero   (out_zero),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    // Combinational ALU model: 001 add, 010 sub, others simple logic ops.
    always_comb begin
        alu_y = '0;
        case (alu_op_code)
            3'b000:  alu_y = alu_a & alu_b;
            3'b001:  alu_y = alu_a + alu_b;
            3'b010:  alu_y = alu_a - alu_b;
            3'b011:  alu_y = alu_a | alu_b;
            3'b100:  alu_y = alu_a ^ alu_b;
            default: alu_y = '0;
        endcase
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic set_cmd(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic use_acc);
        in_valid   = 1'b1;
        in_op      = op;
        in_a       = a;
        in_b       = b;
        in_use_acc = use_acc;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0;
        in_use_acc = 1'b0; acc_clr = 1'b0; out_ready = 1'b0;
        repeat (2) step();
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        tests++; if (out_y !== 32'h0) begin fails++; $display("FAIL reset_out_y: got %h want 0", out_y); end
        tests++; if (out_zero !== 1'b0) begin fails++; $display("FAIL reset_out_zero: got %b want 0", out_zero); end
        tests++; if (fifo_count !== 3'd0) begin fails++; $display("FAIL reset_count: got %0d want 0", fifo_count); end
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        tests++; if ({alu_op_code, alu_a, alu_b} !== 67'h0) begin fails++; $display("FAIL reset_alu: got %h/%h/%h want 0", alu_op_code, alu_a, alu_b); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_basic;
        out_ready = 1'b1;
        set_cmd(3'b001, 32'hA, 32'h5, 1'b0);
        step();  // E0: accepted
        in_valid = 1'b0;
        tests++; if (fifo_count !== 3'd1) begin fails++; $display("FAIL basic_count_e0: got %0d want 1", fifo_count); end
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL basic_valid_e0: got %b want 0", out_valid); end
        step();  // E1: popped and issued
        tests++; if (alu_op_code !== 3'b001 || alu_a !== 32'hA || alu_b !== 32'h5) begin fails++; $display("FAIL basic_issue: got %b/%h/%h want 001/0000000a/00000005", alu_op_code, alu_a, alu_b); end
        tests++; if (out_valid !== 1'b0 || fifo_count !== 3'd0) begin fails++; $display("FAIL basic_e1: got valid %b count %0d want 0/0", out_valid, fifo_count); end
        step();  // E2: captured
        tests++; if (out_valid !== 1'b1 || out_y !== 32'hF || out_zero !== 1'b0) begin fails++; $display("FAIL basic_result: got %b/%h/%b want 1/0000000f/0", out_valid, out_y, out_zero); end
        step();  // E3: consumed
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL basic_consumed: got %b want 0", out_valid); end
    endtask

    task automatic test_chain;
        set_cmd(3'b001, 32'hDEADBEEF, 32'h5, 1'b1);
        step();
        in_valid = 1'b0;
        step();
        tests++; if (alu_a !== 32'hF || alu_b !== 32'h5) begin fails++; $display("FAIL chain_alu_a: got %h/%h want 0000000f/00000005", alu_a, alu_b); end
        step();
        tests++; if (out_valid !== 1'b1 || out_y !== 32'h14) begin fails++; $display("FAIL chain_out_y: got %b/%h want 1/00000014", out_valid, out_y); end
        step();
        acc_clr = 1'b1;
        step();
        acc_clr = 1'b0;
        set_cmd(3'b001, 32'h12345678, 32'h3, 1'b1);
        step();
        in_valid = 1'b0;
        step();
        tests++; if (alu_a !== 32'h0) begin fails++; $display("FAIL clr_alu_a: got %h want 0", alu_a); end
        step();
        tests++; if (out_y !== 32'h3) begin fails++; $display("FAIL clr_out_y: got %h want 00000003", out_y); end
        step();
        // acc_clr coincident with capture: result still delivered, accumulator cleared
        set_cmd(3'b001, 32'h7, 32'h2, 1'b0);
        step();
        in_valid = 1'b0;
        step();
        acc_clr = 1'b1;
        step();
        acc_clr = 1'b0;
        tests++; if (out_valid !== 1'b1 || out_y !== 32'h9) begin fails++; $display("FAIL clr_capture_out_y: got %b/%h want 1/00000009", out_valid, out_y); end
        step();
        set_cmd(3'b001, 32'hAAAA, 32'h4, 1'b1);
        step();
        in_valid = 1'b0;
        step();
        tests++; if (alu_a !== 32'h0) begin fails++; $display("FAIL clr_capture_acc: got %h want 0", alu_a); end
        step();
        tests++; if (out_y !== 32'h4) begin fails++; $display("FAIL clr_capture_next: got %h want 00000004", out_y); end
        step();
    endtask

    task automatic test_zero_wrap;
        set_cmd(3'b010, 32'h5, 32'h5, 1'b0);
        step();
        in_valid = 1'b0;
        repeat (2) step();
        tests++; if (out_valid !== 1'b1 || out_y !== 32'h0 || out_zero !== 1'b1) begin fails++; $display("FAIL zero_sub: got %b/%h/%b want 1/00000000/1", out_valid, out_y, out_zero); end
        step();
        set_cmd(3'b001, 32'hFFFFFFFF, 32'h1, 1'b0);
        step();
        in_valid = 1'b0;
        repeat (2) step();
        tests++; if (out_valid !== 1'b1 || out_y !== 32'h0 || out_zero !== 1'b1) begin fails++; $display("FAIL zero_wrap: got %b/%h/%b want 1/00000000/1", out_valid, out_y, out_zero); end
        step();
    endtask

    // Command i is {add, i<<4, i}, giving result 17*i.
    task automatic test_backpressure;
        out_ready = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            set_cmd(3'b001, 32'(i) << 4, 32'(i), 1'b0);
            step();
        end
        // Sixth command stays presented: one issued, four queued, FIFO full.
        for (int k = 0; k < 3; k++) begin
            tests++; if (fifo_count !== 3'd4 || in_ready !== 1'b0) begin fails++; $display("FAIL bp_full_%0d: got count %0d ready %b want 4/0", k, fifo_count, in_ready); end
            tests++; if (out_valid !== 1'b1 || out_y !== 32'd17) begin fails++; $display("FAIL bp_stall_%0d: got %b/%h want 1/00000011", k, out_valid, out_y); end
            step();
        end
    endtask

    task automatic test_full_with_pop;
        out_ready = 1'b1;  // in_valid still high with the sixth command
        step();
        tests++; if (fifo_count !== 3'd3 || out_valid !== 1'b0) begin fails++; $display("FAIL fwp_pop: got count %0d valid %b want 3/0", fifo_count, out_valid); end
        tests++; if (alu_a !== 32'd32 || in_ready !== 1'b1) begin fails++; $display("FAIL fwp_issue: got alu_a %h ready %b want 00000020/1", alu_a, in_ready); end
        step();
        in_valid = 1'b0;
        tests++; if (fifo_count !== 3'd4 || out_valid !== 1'b1 || out_y !== 32'd34) begin fails++; $display("FAIL fwp_push: got count %0d valid %b y %h want 4/1/00000022", fifo_count, out_valid, out_y); end
        for (int k = 3; k <= 6; k++) begin
            step();
            tests++; if (out_valid !== 1'b0 || fifo_count !== 3'(6 - k)) begin fails++; $display("FAIL drain_pop_%0d: got valid %b count %0d want 0/%0d", k, out_valid, fifo_count, 6 - k); end
            step();
            tests++; if (out_valid !== 1'b1 || out_y !== 32'(17 * k)) begin fails++; $display("FAIL drain_y_%0d: got %b/%h want 1/%h", k, out_valid, out_y, 32'(17 * k)); end
        end
        step();
        tests++; if (out_valid !== 1'b0 || fifo_count !== 3'd0) begin fails++; $display("FAIL drain_end: got valid %b count %0d want 0/0", out_valid, fifo_count); end
    endtask

    task automatic test_reset_mid_op;
        out_ready = 1'b0;
        set_cmd(3'b001, 32'h100, 32'h23, 1'b0);
        step();
        set_cmd(3'b001, 32'h1, 32'h1, 1'b0);
        step();
        set_cmd(3'b001, 32'h2, 32'h2, 1'b0);
        step();
        in_valid = 1'b0;
        tests++; if (fifo_count !== 3'd2 || out_valid !== 1'b1 || out_y !== 32'h123) begin fails++; $display("FAIL rmo_pre: got count %0d valid %b y %h want 2/1/00000123", fifo_count, out_valid, out_y); end
        #3 rst_n = 1'b0;
        #1;
        tests++; if (out_valid !== 1'b0 || fifo_count !== 3'd0 || out_y !== 32'h0) begin fails++; $display("FAIL rmo_async: got valid %b count %0d y %h want 0/0/0", out_valid, fifo_count, out_y); end
        tests++; if ({alu_op_code, alu_a, alu_b} !== 67'h0) begin fails++; $display("FAIL rmo_alu: got %h/%h/%h want 0", alu_op_code, alu_a, alu_b); end
        #2 rst_n = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            tests++; if (out_valid !== 1'b0 || fifo_count !== 3'd0) begin fails++; $display("FAIL rmo_quiet_%0d: got valid %b count %0d want 0/0", k, out_valid, fifo_count); end
        end
        // Accumulator was cleared by reset, so a chained command sees zero.
        set_cmd(3'b001, 32'h55, 32'h1, 1'b1);
        step();
        in_valid = 1'b0;
        step();
        tests++; if (alu_a !== 32'h0) begin fails++; $display("FAIL rmo_acc: got %h want 0", alu_a); end
        step();
        tests++; if (out_valid !== 1'b1 || out_y !== 32'h1) begin fails++; $display("FAIL rmo_new: got %b/%h want 1/00000001", out_valid, out_y); end
        step();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_chain();
        test_zero_wrap();
        test_backpressure();
        test_full_with_pop();
        test_reset_mid_op();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
